// File: rtl/mem_responder_if.sv
// Bus between the CPU memory sequencer and mem_responder: request side
// (req/rw/ao/wdata), response side (edb/ack/busy/err) plus the FSM state for observation.
interface mem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    // Handshake: the master raises req with rw/ao/wdata and holds it until it samples
    // ack=1, then drops req on that same edge. ack is a one-cycle pulse; a req still
    // high once the responder is back in IDLE starts a new transaction.
    logic              req;
    logic              rw;
    logic [ADDR_W-1:0] ao;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] edb;
    logic              ack;
    logic              busy;
    logic              err;
    logic [1:0]        dbg_state;

    modport master (
        output req, rw, ao, wdata,
        input  edb, ack, busy, err, dbg_state
    );

    modport slave (
        input  req, rw, ao, wdata,
        output edb, ack, busy, err, dbg_state
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM responder: captures a request, waits WAIT_STATES cycles, pulses ack.
// Optional write protection of addresses <= PROT_TOP is enabled by defining MEM_WRPROT_EN.
module mem_responder #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 8,
    parameter int                WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] PROT_TOP    = ADDR_W'(8'h0F)
) (
    input logic            clock,
    input logic            reset_n,
    mem_responder_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam int        DEPTH = 1 << ADDR_W;
    localparam logic [3:0] WS   = 4'(WAIT_STATES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] edb_q, edb_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              enter_ack;
    logic              prot_hit;
    logic              mem_we;

    // Next state and request capture; req and the bus fields only matter in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.ao;
                    rw_d    = bus.rw;
                    wdata_d = bus.wdata;
                    cnt_d   = WS;
                    state_d = (WS != 4'd0) ? ST_WAIT : ST_ACK;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef MEM_WRPROT_EN
    logic err_q, err_d;

    always_comb begin
        prot_hit = (addr_d <= PROT_TOP);
    end
`else
    logic unused_prot;

    // PROT_TOP has no effect without write protection.
    assign unused_prot = ^PROT_TOP;

    always_comb begin
        prot_hit = 1'b0;
    end
`endif

    // The memory access happens on the edge that enters ACK, using the captured request.
    always_comb begin
        enter_ack = (state_d == ST_ACK) && (state_q != ST_ACK);
        mem_we    = reset_n && enter_ack && !rw_d && !prot_hit;
        edb_d     = edb_q;
        if (enter_ack && rw_d) begin
            edb_d = mem_q[addr_d];
        end
        ack_d  = (state_d == ST_ACK);
        busy_d = (state_d != ST_IDLE);
`ifdef MEM_WRPROT_EN
        err_d  = enter_ack && !rw_d && prot_hit;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            edb_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            edb_q   <= edb_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

`ifdef MEM_WRPROT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // RAM contents survive reset; mem_we is already gated off while reset is low.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[addr_d] <= wdata_d;
        end
    end

    assign bus.edb       = edb_q;
    assign bus.ack       = ack_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_STATES 0, 1, 3) driven in lockstep
// and checked against a word-array reference model with an expected-data queue.
module tb_mem_responder;
  logic clock;
  logic reset_n;

  mem_responder_if #(.DATA_W(16), .ADDR_W(8)) bus0 ();
  mem_responder_if #(.DATA_W(16), .ADDR_W(8)) bus1 ();
  mem_responder_if #(.DATA_W(16), .ADDR_W(8)) bus2 ();

  mem_responder #(.WAIT_STATES(0)) u_dut0 (.clock(clock), .reset_n(reset_n), .bus(bus0));
  mem_responder #(.WAIT_STATES(1)) u_dut1 (.clock(clock), .reset_n(reset_n), .bus(bus1));
  mem_responder #(.WAIT_STATES(3)) u_dut2 (.clock(clock), .reset_n(reset_n), .bus(bus2));

  logic        req_a   [3];
  logic        rw_a    [3];
  logic [7:0]  ao_a    [3];
  logic [15:0] wdata_a [3];
  logic        ack_a   [3];
  logic        busy_a  [3];
  logic        err_a   [3];
  logic [15:0] edb_a   [3];

  assign bus0.req = req_a[0];  assign bus0.rw = rw_a[0];
  assign bus0.ao  = ao_a[0];   assign bus0.wdata = wdata_a[0];
  assign bus1.req = req_a[1];  assign bus1.rw = rw_a[1];
  assign bus1.ao  = ao_a[1];   assign bus1.wdata = wdata_a[1];
  assign bus2.req = req_a[2];  assign bus2.rw = rw_a[2];
  assign bus2.ao  = ao_a[2];   assign bus2.wdata = wdata_a[2];

  assign ack_a[0] = bus0.ack;  assign busy_a[0] = bus0.busy;
  assign err_a[0] = bus0.err;  assign edb_a[0]  = bus0.edb;
  assign ack_a[1] = bus1.ack;  assign busy_a[1] = bus1.busy;
  assign err_a[1] = bus1.err;  assign edb_a[1]  = bus1.edb;
  assign ack_a[2] = bus2.ack;  assign busy_a[2] = bus2.busy;
  assign err_a[2] = bus2.err;  assign edb_a[2]  = bus2.edb;

  // reference model: per-instance memory image, known flags, last read value
  logic [15:0] mdl_mem [3][256];
  bit          mdl_vld [3][256];
  logic [15:0] last_rd [3];
  bit          last_known [3];
  logic [16:0] exp_q[$];
  int          ack_cnt [3];
  int          n_cmp = 0;
  int          n_err = 0;

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (ack_a[k] === 1'b1) ack_cnt[k] = ack_cnt[k] + 1;
    end
  end

  function automatic int ws_of(input int k);
    case (k)
      0: return 0;
      1: return 1;
      default: return 3;
    endcase
  endfunction

  function automatic bit prot_of(input logic [7:0] a);
`ifdef MEM_WRPROT_EN
    return (a <= 8'h0F);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one transaction on every instance selected by mask
  task automatic do_txn(input logic [2:0] mask, input logic rd, input logic [7:0] addr,
                        input logic [15:0] data, input bit glitch);
    logic [2:0]  pending;
    logic        exp_err [3];
    int          base [3];
    logic [16:0] e;
    int          cyc;
    for (int k = 0; k < 3; k++) begin
      exp_err[k] = 1'b0;
      base[k] = ack_cnt[k];
      if (mask[k]) begin
        if (rd) begin
          last_rd[k] = mdl_mem[k][addr];
          last_known[k] = mdl_vld[k][addr];
        end else if (prot_of(addr)) begin
          exp_err[k] = 1'b1;
        end else begin
          mdl_mem[k][addr] = data;
          mdl_vld[k][addr] = 1'b1;
        end
        exp_q.push_back({last_known[k], last_rd[k]});
        req_a[k] = 1'b1; rw_a[k] = rd; ao_a[k] = addr; wdata_a[k] = data;
      end
    end
    pending = mask;
    cyc = 0;
    while (pending != 3'b000 && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
      for (int k = 0; k < 3; k++) begin
        if (pending[k] && ack_a[k] === 1'b1) begin
          e = exp_q.pop_front();
          check($sformatf("latency[%0d] a=%0h", k, addr), cyc, ws_of(k) + 1);
          check($sformatf("busy_at_ack[%0d]", k), busy_a[k], 1);
          check($sformatf("err[%0d] a=%0h", k, addr), err_a[k], exp_err[k]);
          if (e[16]) check($sformatf("edb[%0d] a=%0h rd=%0b", k, addr, rd), edb_a[k], e[15:0]);
          req_a[k] = 1'b0;
          pending[k] = 1'b0;
        end
      end
      if (glitch) begin
        for (int k = 0; k < 3; k++) begin
          if (pending[k] && cyc == 1) begin
            ao_a[k] = addr + 8'd1;
            req_a[k] = 1'b0;
          end
          if (pending[k] && cyc == 2) req_a[k] = 1'b1;
        end
      end
    end
    if (pending != 3'b000) begin
      check("ack_timeout", pending, 0);
      for (int k = 0; k < 3; k++) req_a[k] = 1'b0;
      exp_q.delete();
    end
    @(posedge clock); #1;
    for (int k = 0; k < 3; k++) begin
      if (mask[k]) begin
        check($sformatf("idle_busy[%0d]", k), busy_a[k], 0);
        check($sformatf("idle_ack[%0d]", k), ack_a[k], 0);
        check($sformatf("idle_err[%0d]", k), err_a[k], 0);
        check($sformatf("ack_count[%0d]", k), ack_cnt[k] - base[k], 1);
        if (last_known[k]) check($sformatf("edb_hold[%0d]", k), edb_a[k], last_rd[k]);
      end
    end
  endtask

  // asynchronous reset pulse, then ten idle cycles with no ack
  task automatic pulse_reset();
    int base [3];
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_ack[%0d]", k), ack_a[k], 0);
      check($sformatf("rst_busy[%0d]", k), busy_a[k], 0);
      check($sformatf("rst_edb[%0d]", k), edb_a[k], 16'h0000);
      check($sformatf("rst_err[%0d]", k), err_a[k], 0);
      last_rd[k] = 16'h0000;
      last_known[k] = 1'b1;
      req_a[k] = 1'b0;
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) base[k] = ack_cnt[k];
    repeat (10) @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("post_rst_acks[%0d]", k), ack_cnt[k] - base[k], 0);
      check($sformatf("post_rst_busy[%0d]", k), busy_a[k], 0);
    end
  endtask

  // write aborted by reset while the waiting instances are still in WAIT
  task automatic reset_mid_write(input logic [7:0] addr, input logic [15:0] data);
    for (int k = 1; k < 3; k++) begin
      req_a[k] = 1'b1; rw_a[k] = 1'b0; ao_a[k] = addr; wdata_a[k] = data;
    end
    @(posedge clock); #1;
    for (int k = 1; k < 3; k++) check($sformatf("midwr_busy[%0d]", k), busy_a[k], 1);
    pulse_reset();
  endtask

  initial begin
    logic       rd;
    logic [7:0] a;
    for (int k = 0; k < 3; k++) begin
      req_a[k] = 1'b0; rw_a[k] = 1'b0; ao_a[k] = 8'h00; wdata_a[k] = 16'h0000;
      ack_cnt[k] = 0; last_rd[k] = 16'h0000; last_known[k] = 1'b1;
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
    pulse_reset();

    do_txn(3'b111, 1'b0, 8'h20, 16'hBEEF, 1'b0);
    do_txn(3'b111, 1'b1, 8'h20, 16'h0000, 1'b0);
    pulse_reset();

    do_txn(3'b111, 1'b0, 8'h00, 16'h1234, 1'b0);
    do_txn(3'b111, 1'b0, 8'hFF, 16'h5678, 1'b0);
    do_txn(3'b111, 1'b1, 8'hFF, 16'h0000, 1'b0);
    do_txn(3'b111, 1'b1, 8'h00, 16'h0000, 1'b0);

    do_txn(3'b111, 1'b0, 8'h21, 16'h1111, 1'b0);
    do_txn(3'b111, 1'b1, 8'h20, 16'h0000, 1'b1);

    do_txn(3'b111, 1'b0, 8'h30, 16'h0BAD, 1'b0);
    reset_mid_write(8'h30, 16'hDEAD);
    do_txn(3'b111, 1'b1, 8'h30, 16'h0000, 1'b0);

    do_txn(3'b111, 1'b0, 8'h05, 16'hAAAA, 1'b0);
    do_txn(3'b111, 1'b1, 8'h05, 16'h0000, 1'b0);
    do_txn(3'b111, 1'b0, 8'h10, 16'hC0DE, 1'b0);
    do_txn(3'b111, 1'b1, 8'h10, 16'h0000, 1'b0);

    for (int i = 0; i < 60; i++) begin
      rd = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 255));
      if (rd && !(mdl_vld[0][a] && mdl_vld[1][a] && mdl_vld[2][a])) rd = 1'b0;
      do_txn(3'b111, rd, a, 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
